alu_cmd_sequencer: RTL and testbench

Master-side driver for the 4-bit ALU datapath in the 8-bit CPU project. It buffers incoming ALU commands (opcode plus two operands) in a small FIFO, drives them onto the ALU's opcode/in_1/in_2/en pins one at a time, and waits a fixed ALU latency before capturing alu_out. Each captured result is then presented on a valid/ready result port. It sits between the instruction-decode front end and the ALU.

---
 rtl/alu_cmd_sequencer_if.sv | 24 ++
 rtl/alu_cmd_sequencer.sv | 117 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
`timescale 1ns/1ps
// alu_cmd_sequencer_if: command, ALU pin and result bundle of the ALU command sequencer
interface alu_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_data;
    logic        alu_en;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_in_1;
    logic [3:0]  alu_in_2;
    logic [3:0]  alu_out;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_data;
    logic        busy;
    modport master (
        input  cmd_valid, cmd_data, alu_out, res_ready,
        output cmd_ready, alu_en, alu_opcode, alu_in_1, alu_in_2, res_valid, res_data, busy
    );
    modport slave (
        output cmd_valid, cmd_data, alu_out, res_ready,
        input  cmd_ready, alu_en, alu_opcode, alu_in_1, alu_in_2, res_valid, res_data, busy
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
// alu_cmd_sequencer: FIFO-buffered ALU command issue with fixed-latency capture and valid/ready results.
// Optional ALU_CHAIN_EN: a set chain flag feeds the previous result in place of operand A.
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input logic clk,
    input logic rst,
    alu_cmd_sequencer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [11:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic rdy_q, rdy_d;
    logic [3:0] wait_q, wait_d;
    logic en_q, en_d;
    logic [2:0] op_q, op_d;
    logic [3:0] in1_q, in1_d, in2_q, in2_d;
    logic rv_q, rv_d;
    logic [3:0] rdat_q, rdat_d;
    logic [3:0] last_q, last_d;
    logic [11:0] head;
    logic [3:0] opa;
    logic push, pop;
    assign head = mem_q[rd_q];
    assign push = bus.cmd_valid && rdy_q;
`ifdef ALU_CHAIN_EN
    assign opa = head[11] ? last_q : head[7:4];
    always_comb last_d = (state_q == WAIT && wait_q == 4'd0) ? bus.alu_out : last_q;
`else
    logic unused_chain;
    assign opa = head[7:4];
    assign unused_chain = head[11] ^ (|last_q);
    always_comb last_d = 4'd0;
`endif
    always_comb begin
        state_d = state_q;
        pop = 1'b0;
        wait_d = wait_q;
        rv_d = rv_q;
        rdat_d = rdat_q;
        case (state_q)
            IDLE: pop = cnt_q != '0;
            ISSUE: begin
                state_d = WAIT;
                wait_d = 4'(ALU_LAT - 1);
            end
            WAIT: begin
                state_d = (wait_q == 4'd0) ? RESP : WAIT;
                rv_d = wait_q == 4'd0;
                rdat_d = (wait_q == 4'd0) ? bus.alu_out : rdat_q;
                wait_d = (wait_q == 4'd0) ? wait_q : wait_q - 4'd1;
            end
            RESP: if (bus.res_ready) begin
                state_d = IDLE;
                rv_d = 1'b0;
                pop = cnt_q != '0;
            end
            default: state_d = IDLE;
        endcase
        // A pop always launches the next issue, whether from IDLE or straight out of RESP
        state_d = pop ? ISSUE : state_d;
        en_d = pop;
        op_d = pop ? head[10:8] : 3'd0;
        in1_d = pop ? opa : 4'd0;
        in2_d = pop ? head[3:0] : 4'd0;
        wr_d = wr_q + AW'(push);
        rd_d = rd_q + AW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        rdy_d = cnt_d < CW'(DEPTH);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
            wait_q <= 4'd0;
            en_q <= 1'b0;
            op_q <= 3'd0;
            in1_q <= 4'd0;
            in2_q <= 4'd0;
            rv_q <= 1'b0;
            rdat_q <= 4'd0;
            last_q <= 4'd0;
        end else begin
            state_q <= state_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
            wait_q <= wait_d;
            en_q <= en_d;
            op_q <= op_d;
            in1_q <= in1_d;
            in2_q <= in2_d;
            rv_q <= rv_d;
            rdat_q <= rdat_d;
            last_q <= last_d;
        end
    end
    always_ff @(posedge clk) if (push) mem_q[wr_q] <= bus.cmd_data;
    assign bus.cmd_ready = rdy_q;
    assign bus.alu_en = en_q;
    assign bus.alu_opcode = op_q;
    assign bus.alu_in_1 = in1_q;
    assign bus.alu_in_2 = in2_q;
    assign bus.res_valid = rv_q;
    assign bus.res_data = rdat_q;
    assign bus.busy = state_q != IDLE || cnt_q != '0;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
// tb_alu_cmd_sequencer: randomized bench; expected issues/results come from a queue-based command model.
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int LAT = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hold_err = 0;
    int ovl_err = 0;
    logic prev_stall = 1'b0;
    logic [3:0] prev_rd = 4'd0;
    logic [3:0] m_last;
    logic [11:0] acc_q[$];
    int acc_cyc[$];
    logic [10:0] iss_q[$];
    int iss_cyc[$];
    logic [3:0] res_q[$];
    int res_cyc[$];
    logic [10:0] exp_iss[$];
    logic [3:0] exp_res[$];

    alu_cmd_sequencer_if bus();
    alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return {a[2:0], 1'b0};
            default: return {1'b0, a[3:1]};
        endcase
    endfunction

    // Registered ALU: result is stable one edge after the enable cycle
    always @(posedge clk) if (bus.alu_en) bus.alu_out <= alu_f(bus.alu_opcode, bus.alu_in_1, bus.alu_in_2);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) prev_stall <= 1'b0;
        else begin
            if (bus.cmd_valid && bus.cmd_ready) begin acc_q.push_back(bus.cmd_data); acc_cyc.push_back(cyc); end
            if (bus.alu_en) begin iss_q.push_back({bus.alu_opcode, bus.alu_in_1, bus.alu_in_2}); iss_cyc.push_back(cyc); end
            if (bus.res_valid && bus.res_ready) begin res_q.push_back(bus.res_data); res_cyc.push_back(cyc); end
            if (prev_stall && (!bus.res_valid || bus.res_data !== prev_rd)) hold_err <= hold_err + 1;
            if (bus.alu_en && bus.res_valid) ovl_err <= ovl_err + 1;
            prev_stall <= bus.res_valid && !bus.res_ready;
            prev_rd <= bus.res_data;
        end
    end

    function automatic void run_model();
        exp_iss.delete();
        exp_res.delete();
        foreach (acc_q[i]) begin
            logic [3:0] a;
            logic [3:0] r;
            a = acc_q[i][7:4];
`ifdef ALU_CHAIN_EN
            if (acc_q[i][11]) a = m_last;
`endif
            r = alu_f(acc_q[i][10:8], a, acc_q[i][3:0]);
            exp_iss.push_back({acc_q[i][10:8], a, acc_q[i][3:0]});
            exp_res.push_back(r);
            m_last = r;
        end
    endfunction

    function automatic void clear_obs();
        acc_q.delete(); acc_cyc.delete();
        iss_q.delete(); iss_cyc.delete();
        res_q.delete(); res_cyc.delete();
    endfunction

    task automatic push(input logic [11:0] d);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data = d;
        while (!bus.cmd_ready && n < 300) begin @(negedge clk); n++; end
        if (!bus.cmd_ready) begin failures++; $display("FAIL push_timeout data=%h cmd_ready=%b required=1", d, bus.cmd_ready); end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        bus.res_ready = 1'b1;
        while ((bus.busy || bus.res_valid) && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (bus.busy || bus.res_valid) begin failures++; $display("FAIL drain_timeout busy=%b res_valid=%b required=0", bus.busy, bus.res_valid); end
    endtask

    task automatic test_reset();
        int n;
        int seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.alu_en, bus.res_valid, bus.busy} !== 4'b0) begin
            failures++; $display("FAIL reset_state got=%b required=0000", {bus.cmd_ready, bus.alu_en, bus.res_valid, bus.busy});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL release_ready cmd_ready=%b busy=%b required=1/0", bus.cmd_ready, bus.busy);
        end
        @(negedge clk);
        bus.res_ready = 1'b0;
        push(12'h1AB);
        n = 0;
        while (!bus.alu_en && n < 20) begin @(negedge clk); n++; end
        checks++;
        if ({bus.alu_en, bus.alu_opcode, bus.alu_in_1, bus.alu_in_2} !== {1'b1, 3'd1, 4'hA, 4'hB}) begin
            failures++; $display("FAIL pre_reset_issue got=%h required=%h", {bus.alu_en, bus.alu_opcode, bus.alu_in_1, bus.alu_in_2}, {1'b1, 3'd1, 4'hA, 4'hB});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.alu_en, bus.alu_opcode, bus.alu_in_1, bus.alu_in_2, bus.res_valid, bus.res_data, bus.busy} !== '0) begin
            failures++; $display("FAIL async_reset_issue got=%h required=0", {bus.cmd_ready, bus.alu_en, bus.alu_opcode, bus.alu_in_1, bus.alu_in_2, bus.res_valid, bus.res_data, bus.busy});
        end
        @(negedge clk);
        rst = 1'b0;
        push(12'h0F3);
        n = 0;
        while (!bus.res_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 4'd2) begin
            failures++; $display("FAIL pre_reset_result valid=%b data=%0d required=1/2", bus.res_valid, bus.res_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.alu_en, bus.res_valid, bus.res_data, bus.busy} !== '0) begin
            failures++; $display("FAIL async_reset_resp got=%h required=0", {bus.cmd_ready, bus.alu_en, bus.res_valid, bus.res_data, bus.busy});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin @(negedge clk); if (bus.res_valid || bus.alu_en) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL reset_discard activity=%0d required=0", seen); end
        m_last = 4'd0;
        clear_obs();
    endtask

    task automatic test_single();
        clear_obs();
        bus.res_ready = 1'b1;
        push(12'h034);
        wait_idle();
        run_model();
        checks++;
        if (acc_q.size() != 1 || iss_q.size() != 1 || res_q.size() != 1) begin
            failures++; $display("FAIL single_counts acc=%0d iss=%0d res=%0d required=1/1/1", acc_q.size(), iss_q.size(), res_q.size());
        end else begin
            checks++;
            if (iss_q[0] !== exp_iss[0]) begin failures++; $display("FAIL single_issue got=%h required=%h", iss_q[0], exp_iss[0]); end
            checks++;
            if (iss_cyc[0] - acc_cyc[0] != 2) begin failures++; $display("FAIL single_issue_lat got=%0d required=2", iss_cyc[0] - acc_cyc[0]); end
            checks++;
            if (res_q[0] !== 4'd7) begin failures++; $display("FAIL single_result got=%0d required=7", res_q[0]); end
            checks++;
            if (res_cyc[0] - acc_cyc[0] != 3 + LAT) begin failures++; $display("FAIL single_result_lat got=%0d required=%0d", res_cyc[0] - acc_cyc[0], 3 + LAT); end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        clear_obs();
        bus.res_ready = 1'b0;
        push(12'h012);
        push(12'h056);
        push(12'h0FF);
        while (!bus.res_valid && n < 30) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 4'd3 || bus.alu_en !== 1'b0) begin
            failures++; $display("FAIL stall_hold valid=%b data=%0d alu_en=%b required=1/3/0", bus.res_valid, bus.res_data, bus.alu_en);
        end
        wait_idle();
        run_model();
        checks++;
        if (res_q.size() != 3 || iss_q.size() != 3) begin
            failures++; $display("FAIL b2b_counts res=%0d iss=%0d required=3/3", res_q.size(), iss_q.size());
        end else begin
            checks++;
            if ({res_q[0], res_q[1], res_q[2]} !== {4'd3, 4'd11, 4'd14}) begin
                failures++; $display("FAIL b2b_results got=%0d,%0d,%0d required=3,11,14", res_q[0], res_q[1], res_q[2]);
            end
            foreach (exp_iss[i]) begin
                checks++;
                if (iss_q[i] !== exp_iss[i]) begin failures++; $display("FAIL b2b_issue%0d got=%h required=%h", i, iss_q[i], exp_iss[i]); end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (iss_cyc[i + 1] != res_cyc[i] + 1) begin
                    failures++; $display("FAIL b2b_gap%0d issue_edge=%0d required=%0d", i, iss_cyc[i + 1], res_cyc[i] + 1);
                end
            end
        end
        checks++;
        if (hold_err != 0 || ovl_err != 0) begin failures++; $display("FAIL b2b_protocol hold_err=%0d ovl_err=%0d required=0/0", hold_err, ovl_err); end
    endtask

    task automatic test_full();
        int n = 0;
        clear_obs();
        bus.res_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(12'($urandom));
        checks++;
        if (bus.cmd_ready !== 1'b0 || acc_q.size() != DEPTH + 1) begin
            failures++; $display("FAIL full_ready cmd_ready=%b accepted=%0d required=0/%0d", bus.cmd_ready, acc_q.size(), DEPTH + 1);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_data = 12'($urandom);
        repeat (6) @(negedge clk);
        checks++;
        if (acc_q.size() != DEPTH + 1 || bus.cmd_ready !== 1'b0) begin
            failures++; $display("FAIL full_block accepted=%0d cmd_ready=%b required=%0d/0", acc_q.size(), bus.cmd_ready, DEPTH + 1);
        end
        bus.res_ready = 1'b1;
        while (acc_q.size() < DEPTH + 2 && n < 50) begin @(negedge clk); n++; end
        bus.cmd_valid = 1'b0;
        wait_idle();
        run_model();
        checks++;
        if (acc_q.size() != DEPTH + 2 || res_q.size() != DEPTH + 2) begin
            failures++; $display("FAIL full_counts acc=%0d res=%0d required=%0d", acc_q.size(), res_q.size(), DEPTH + 2);
        end else begin
            checks++;
            if (acc_cyc[DEPTH + 1] != res_cyc[0] + 1) begin
                failures++; $display("FAIL full_accept_edge got=%0d required=%0d", acc_cyc[DEPTH + 1], res_cyc[0] + 1);
            end
            foreach (exp_res[i]) begin
                checks++;
                if (res_q[i] !== exp_res[i]) begin failures++; $display("FAIL full_result%0d got=%0d required=%0d", i, res_q[i], exp_res[i]); end
            end
        end
    endtask

    task automatic test_throughput();
        clear_obs();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) push({1'b0, 3'($urandom), 8'($urandom)});
        wait_idle();
        run_model();
        checks++;
        if (iss_q.size() != 4 || res_q.size() != 4) begin
            failures++; $display("FAIL tput_counts iss=%0d res=%0d required=4/4", iss_q.size(), res_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (iss_cyc[i + 1] - iss_cyc[i] != LAT + 2) begin
                    failures++; $display("FAIL tput_spacing%0d got=%0d required=%0d", i, iss_cyc[i + 1] - iss_cyc[i], LAT + 2);
                end
            end
            foreach (exp_res[i]) begin
                checks++;
                if (res_q[i] !== exp_res[i]) begin failures++; $display("FAIL tput_result%0d got=%0d required=%0d", i, res_q[i], exp_res[i]); end
            end
        end
    endtask

    task automatic test_reset_wait();
        int n = 0;
        int seen = 0;
        clear_obs();
        bus.res_ready = 1'b1;
        push(12'($urandom));
        push(12'($urandom));
        while (!bus.alu_en && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        clear_obs();
        m_last = 4'd0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL wait_reset valid=%b busy=%b required=0/0", bus.res_valid, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin @(negedge clk); if (bus.res_valid || bus.alu_en || bus.busy) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL wait_reset_quiet activity=%0d required=0", seen); end
        push(12'h162);
        wait_idle();
        run_model();
        checks++;
        if (res_q.size() != 1 || iss_q.size() != 1) begin
            failures++; $display("FAIL wait_reset_next res=%0d iss=%0d required=1/1", res_q.size(), iss_q.size());
        end else begin
            checks++;
            if (res_q[0] !== 4'd4 || iss_q[0] !== exp_iss[0]) begin
                failures++; $display("FAIL wait_reset_result got=%0d/%h required=4/%h", res_q[0], iss_q[0], exp_iss[0]);
            end
        end
    endtask

    task automatic test_chain();
        logic [3:0] exp_in1;
        logic [3:0] exp_r;
`ifdef ALU_CHAIN_EN
        exp_in1 = 4'd5;
        exp_r = 4'd6;
`else
        exp_in1 = 4'd0;
        exp_r = 4'd1;
`endif
        clear_obs();
        bus.res_ready = 1'b1;
        push(12'h023);
        push(12'h801);
        wait_idle();
        run_model();
        checks++;
        if (iss_q.size() != 2 || res_q.size() != 2) begin
            failures++; $display("FAIL chain_counts iss=%0d res=%0d required=2/2", iss_q.size(), res_q.size());
        end else begin
            checks++;
            if (iss_q[1] !== {3'd0, exp_in1, 4'd1}) begin failures++; $display("FAIL chain_issue got=%h required=%h", iss_q[1], {3'd0, exp_in1, 4'd1}); end
            checks++;
            if (res_q[0] !== 4'd5 || res_q[1] !== exp_r) begin
                failures++; $display("FAIL chain_results got=%0d,%0d required=5,%0d", res_q[0], res_q[1], exp_r);
            end
            checks++;
            if (res_q[1] !== exp_res[1]) begin failures++; $display("FAIL chain_model got=%0d required=%0d", res_q[1], exp_res[1]); end
        end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        clear_obs();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    push(12'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin @(negedge clk); bus.res_ready = 1'($urandom_range(0, 1)); end
            end
        join
        wait_idle();
        run_model();
        checks++;
        if (acc_q.size() != 40 || res_q.size() != 40 || iss_q.size() != 40) begin
            failures++; $display("FAIL rand_counts acc=%0d iss=%0d res=%0d required=40", acc_q.size(), iss_q.size(), res_q.size());
        end else begin
            foreach (exp_res[i]) begin
                checks++;
                if (res_q[i] !== exp_res[i] || iss_q[i] !== exp_iss[i]) begin
                    failures++; $display("FAIL rand_txn%0d got=%0d/%h required=%0d/%h", i, res_q[i], iss_q[i], exp_res[i], exp_iss[i]);
                end
            end
        end
        checks++;
        if (hold_err != 0 || ovl_err != 0) begin failures++; $display("FAIL rand_protocol hold_err=%0d ovl_err=%0d required=0/0", hold_err, ovl_err); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data = 12'h000;
        bus.res_ready = 1'b0;
        m_last = 4'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_throughput();
        test_reset_wait();
        test_chain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t limit=500000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
